exception_ctrl: RTL
===================

# exception_ctrl

Memory-stage exception arbiter sitting directly upstream of the CP0 register file. It collects per-instruction exception flags carried down the pipeline, synchronises external interrupt lines, and checks CP0 state with a write-back bypass. It picks one exception per cycle, drives the exception code, instruction address and delay-slot flag into CP0, and issues the pipeline flush and redirect PC. A drain state machine masks detection while flushed bubbles leave the pipe.

## Interface
- EXC_VECTOR, 32'h0000_0020, redirect PC for every exception except ERET
- DRAIN_CYCLES, 3, cycles detection is masked after a flush (1..15)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- int_i  in  6  asynchronous hardware interrupt lines
- mem_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
- mem_exc_flags_i  in  32  bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret; other bits ignored
- mem_inst_addr_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  WB stage writes CP0 this cycle
- wb_cp0_addr_i  in  5  WB CP0 write address (12 status, 13 cause, 14 epc)
- wb_cp0_data_i  in  32  WB CP0 write data
- int_sync_o  out  6  synchronised interrupts to CP0 interrupt_i
- exception_type_o  out  32  code to CP0; 0 when none
- exc_inst_addr_o  out  32  instruction address to CP0
- exc_in_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect target, valid while flush_o
- exc_count_o  out  16  saturating count of taken exceptions

## Operation
- Interrupt sync: two flops per line, so int_sync_o = int_i delayed 2 cycles. It feeds CP0 and the effective cause IP[7:2].
- Bypass, evaluated combinationally before the checks below:
  - status_eff = wb data if we and addr==12, else cp0_status_i.
  - epc_eff = wb data if we and addr==14, else cp0_epc_i.
  - cause_eff = cp0_cause_i with bits [9:8] replaced by wb data [9:8] if we and addr==13.
- Interrupt pending: (cause_eff[15:8] & status_eff[15:8]) != 0, status_eff[1]==0 (EXL) and status_eff[0]==1 (IE).
- Fixed priority, single winner, 32-bit code:
  - interrupt 0x1, then syscall 0x8, invalid 0xa, trap 0xd, overflow 0xc, eret 0xe.
- Detection qualifier: state RUN and mem_valid_i==1 and rst==0. Otherwise exception_type_o=0 and flush_o=0.
- On detection, all combinational in the same cycle:
  - exception_type_o = code, flush_o=1.
  - new_pc_o = epc_eff for 0xe, EXC_VECTOR otherwise.
- exc_inst_addr_o = mem_inst_addr_i and exc_in_delayslot_o = mem_in_delayslot_i at all times; CP0 applies the delay-slot -4 itself.
- FSM states:
  - RUN to DRAIN on detection; drain counter loads DRAIN_CYCLES.
  - DRAIN: decrement each cycle, return to RUN on the edge where the counter reaches 1. No detection during DRAIN, even with mem_valid_i high.
- exc_count_o increments at the edge after each detection and saturates at 16'hFFFF.
- When flush_o==0, new_pc_o = 0.

## Timing
- Reset (synchronous), effective at the next edge:
  - sync flops = 0, int_sync_o = 0.
  - state = RUN, drain counter = 0, exc_count_o = 0.
  - Combinational outputs are 0 while rst is high.
- Latency:
  - int_i to int_sync_o: 2 edges.
  - int_i to interrupt detection: at least 3 edges, because CP0 registers cause IP one more edge.
  - Detection to flush_o: 0 cycles.
- CP0 samples exception_type_o on the same edge that moves the FSM into DRAIN. flush_o is therefore high for exactly one cycle per exception.
- Simultaneous events:
  - Interrupt plus synchronous exception: the interrupt wins.
  - ERET while the WB write hits EPC: new_pc_o uses the WB data.
  - WB write clearing IE or setting EXL in the same cycle suppresses the interrupt.
- Back-to-back: an exception-flagged instruction arriving during DRAIN is ignored; it is a flushed instruction by construction.
- rst asserted in DRAIN: RUN next edge, no flush pulse.

## Test plan
- Syscall: mem_valid=1, flags bit8, addr 0x1000 -> type 0x8, flush=1, new_pc 0x20; exc_count becomes 1; next 3 cycles flush=0 despite flags held; 4th cycle flush=1 again.
- ERET bypass: cp0_epc=0x400, wb writes epc=0x800, flags bit12 -> type 0xe, new_pc 0x800.
- Interrupt: status=0x0000_0401, int_i[0] raised at cycle 0 -> int_sync_o[0]=1 after 2 edges. Feed cause=0x400 with mem_valid=1 -> type 0x1; same with status EXL=1 (0x403) -> type 0.
- Priority: interrupt pending plus overflow plus invalid -> type 0x1; overflow plus invalid only -> 0xa.
- Bubble: flags bit11 with mem_valid=0 -> type 0, flush 0, count unchanged.
- Reset mid-drain and saturation: rst during DRAIN -> RUN, count 0. Preload 0xFFFF exceptions -> count stays 0xFFFF.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: memory-stage exception arbiter in front of the CP0 register file.
// Ports: clk/rst (sync, active-high); int_i raw interrupts -> int_sync_o; mem_* per-instruction
//   exception flags, PC and delay-slot flag; cp0_* current CP0 state; wb_cp0_* write-back bypass;
//   exception_type_o/exc_inst_addr_o/exc_in_delayslot_o to CP0; flush_o/new_pc_o to the pipeline;
//   exc_count_o saturating count of taken exceptions.
// Latency: detection to flush_o is combinational (0 cycles); int_i to int_sync_o is 2 edges.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_exc_flags_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_addr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] exception_type_o,
  output logic [31:0] exc_inst_addr_o,
  output logic        exc_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [15:0] exc_count_o
);

  localparam logic [4:0]  CP0_STATUS = 5'd12;
  localparam logic [4:0]  CP0_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_EPC    = 5'd14;

  localparam logic [31:0] CODE_INT  = 32'h0000_0001;
  localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
  localparam logic [31:0] CODE_INV  = 32'h0000_000a;
  localparam logic [31:0] CODE_TRAP = 32'h0000_000d;
  localparam logic [31:0] CODE_OV   = 32'h0000_000c;
  localparam logic [31:0] CODE_ERET = 32'h0000_000e;

  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [5:0]  int_meta_q, int_meta_d;
  logic [5:0]  int_sync_q, int_sync_d;
  logic [15:0] exc_count_q, exc_count_d;

  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_pending;
  logic [31:0] exc_code;
  logic        detect;

  // Bits of the CP0 words and flag vector that carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{mem_exc_flags_i[31:13], mem_exc_flags_i[7:0],
                         status_eff[31:16], status_eff[7:2],
                         cause_eff[31:16], cause_eff[7:0]};

  // Write-back bypass: CP0 only sees the WB write on the next edge, so the
  // in-flight value must be used for this cycle's decision.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_addr_i == CP0_STATUS) status_eff = wb_cp0_data_i;
      if (wb_cp0_addr_i == CP0_EPC)    epc_eff    = wb_cp0_data_i;
      // Only the software interrupt bits of cause are writable.
      if (wb_cp0_addr_i == CP0_CAUSE)  cause_eff[9:8] = wb_cp0_data_i[9:8];
    end
  end

  // Masked pending interrupt, with EXL clear and IE set.
  always_comb begin
    int_pending = (|(cause_eff[15:8] & status_eff[15:8])) &&
                  !status_eff[1] && status_eff[0];
  end

  // Fixed priority: interrupt beats every synchronous exception.
  always_comb begin
    exc_code = 32'h0;
    if (int_pending)             exc_code = CODE_INT;
    else if (mem_exc_flags_i[8])  exc_code = CODE_SYS;
    else if (mem_exc_flags_i[9])  exc_code = CODE_INV;
    else if (mem_exc_flags_i[10]) exc_code = CODE_TRAP;
    else if (mem_exc_flags_i[11]) exc_code = CODE_OV;
    else if (mem_exc_flags_i[12]) exc_code = CODE_ERET;
  end

  // Bubbles and anything arriving while flushed work drains are never taken.
  always_comb begin
    detect = (state_q == ST_RUN) && mem_valid_i && !rst && (exc_code != 32'h0);
  end

  always_comb begin
    exception_type_o   = 32'h0;
    flush_o            = 1'b0;
    new_pc_o           = 32'h0;
    exc_inst_addr_o    = 32'h0;
    exc_in_delayslot_o = 1'b0;
    if (!rst) begin
      exc_inst_addr_o    = mem_inst_addr_i;
      exc_in_delayslot_o = mem_in_delayslot_i;
    end
    if (detect) begin
      exception_type_o = exc_code;
      flush_o          = 1'b1;
      new_pc_o         = (exc_code == CODE_ERET) ? epc_eff : EXC_VECTOR;
    end
  end

  // Drain FSM: after a flush, hold off detection for DRAIN_CYCLES cycles so
  // the flushed bubbles cannot raise a second exception.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (detect) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q <= 4'd1) begin
          state_d     = ST_RUN;
          drain_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    int_meta_d  = int_i;
    int_sync_d  = int_meta_q;
    exc_count_d = exc_count_q;
    if (detect && (exc_count_q != 16'hFFFF)) exc_count_d = exc_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 4'd0;
      int_meta_q  <= 6'd0;
      int_sync_q  <= 6'd0;
      exc_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      int_meta_q  <= int_meta_d;
      int_sync_q  <= int_sync_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign int_sync_o  = int_sync_q;
  assign exc_count_o = exc_count_q;

endmodule
